pipeline_hazard_sequencer: RTL and testbench
============================================

// Module: pipeline_hazard_sequencer
// PURPOSE
//  Central stall/flush/halt sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards and inserts one bubble.
//  - Squashes younger instructions on a taken branch or jump resolved in EX.
//  - Sequences HALT (ALUOp=01, Funct3=010, flagged by EX): freeze fetch, drain MEM/WB, park in HALTED.
//  - Keeps saturating stall/flush event counters for debug.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles after HALT leaves EX before halted asserts (MEM+WB depth)
//  CNT_W         32  width of perf counters
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  id_rs1         in   5      rs1 index of instruction in ID
//  id_rs2         in   5      rs2 index of instruction in ID
//  id_use_rs1     in   1      ID instruction reads rs1
//  id_use_rs2     in   1      ID instruction reads rs2
//  ex_mem_read    in   1      EX instruction is a load
//  ex_rd          in   5      destination of EX instruction
//  ex_redirect    in   1      branch taken / JAL / JALR resolved in EX this cycle
//  ex_halt        in   1      valid HALT in EX this cycle
//  pc_write       out  1      PC may update
//  if_id_write    out  1      IF/ID register may load
//  if_id_flush    out  1      IF/ID loads NOP
//  id_ex_flush    out  1      ID/EX loads bubble (all control zero)
//  halted         out  1      pipeline drained and stopped
//  stall_cnt      out  CNT_W  load-use stall cycles since reset
//  flush_cnt      out  CNT_W  redirect flush events since reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=RUN, pc_write=1, if_id_write=1, flushes=0, halted=0, counters=0, drain cnt=0.
//  Hazard term (combinational, RUN only):
//   lu = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
//  Priority, same cycle: ex_halt > ex_redirect > lu.
//  FSM states RUN, DRAIN, HALTED:
//   RUN, ex_halt=1:
//    - pc_write=0, if_id_flush=1, id_ex_flush=1.
//    - load drain cnt = DRAIN_CYCLES-1, next state DRAIN.
//    - Redirect/lu ignored that cycle; neither counter increments.
//   RUN, ex_redirect=1 (no halt):
//    - pc_write=1 (PC takes target), if_id_flush=1, id_ex_flush=1.
//    - flush_cnt+1. lu is ignored: the ID instruction is squashed, not stalled.
//   RUN, lu=1 only:
//    - pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle.
//    - stall_cnt+1. Next cycle the load is in MEM; lu must then be 0.
//   RUN, none: pc_write=1, if_id_write=1, no flush.
//   DRAIN:
//    - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1; all inputs ignored.
//    - Decrement cnt; at cnt==0 go to HALTED.
//   HALTED:
//    - halted=1 (registered), pc_write=0, if_id_write=0, flushes=1.
//    - Sticky until rst_n=0.
//  Output timing: pc_write/if_id_write/flushes are combinational from state+inputs,
//   zero latency, same cycle as the cause. halted and counters are registered.
//  halted latency: rises exactly DRAIN_CYCLES+1 edges after the edge that samples ex_halt.
//  Counters saturate at all-ones; no wrap.
//  Reset mid-DRAIN or in HALTED: immediately RUN, all outputs to reset values.
//  Flush and write-enable never conflict: if_id_flush=1 overrides if_id_write.
//  X on ex_* inputs while in DRAIN/HALTED must not propagate to any output.
// STRUCTURE
//  Shared package pipeline_pkg:
//   - typedef enum logic [1:0] {RUN, DRAIN, HALTED} seq_state_t
//   - localparam REG_IDX_W=5
//   - ALUOP_BRANCH=2'b01, F3_HALT=3'b010 (used by the EX halt decode)
//  One sub-module: sat_counter (width param, inc, async clear), instantiated twice.
//  FSM, drain counter and hazard compare stay in this module.
// TESTING
//  1. Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs1=5:
//     -> pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle; stall_cnt=1.
//  2. ex_rd=0 with ex_mem_read=1, id_rs1=0 used -> no stall; stall_cnt stays 0.
//  3. ex_redirect=1 and lu=1 same cycle -> if_id_flush=id_ex_flush=1, pc_write=1;
//     flush_cnt=1, stall_cnt=0.
//  4. ex_halt pulse with DRAIN_CYCLES=2 -> pc_write=0 from that cycle; halted=1 3 edges later;
//     stays 1 for 20 cycles under random ex_* stimulus.
//  5. rst_n low mid-DRAIN -> state RUN, halted=0, counters 0, pc_write=1 while reset asserted.
//  6. Force stall_cnt to all-ones (CNT_W=4 build, 20 stalls) -> holds 4'hF, no wrap.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control blocks.
// Holds the hazard sequencer state encoding and the EX-stage HALT decode.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } seq_state_t;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [2:0] F3_HALT      = 3'b010;

    // HALT rides on the branch ALUOp with an otherwise unused funct3
    function automatic logic is_halt(input logic [1:0] aluop, input logic [2:0] funct3);
        return (aluop == ALUOP_BRANCH) && (funct3 == F3_HALT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with asynchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until every bit is set, then hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/halt sequencer for the IF/ID/EX/MEM/WB pipeline: load-use bubbles,
// redirect squashes, HALT drain, and saturating debug counters.
module pipeline_hazard_sequencer
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_redirect,
    input  logic                 ex_halt,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t      state_r;
    seq_state_t      state_nxt_s;
    logic [DW-1:0]   drain_cnt_r;
    logic [DW-1:0]   drain_nxt_s;
    logic            halted_r;
    logic            lu_s;
    logic            stall_inc_s;
    logic            flush_inc_s;

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            drain_cnt_r <= {DW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_nxt_s;
        end
    end

    // halted follows HALTED one edge later so it only rises once MEM/WB are empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (state_r == HALTED);
        end
    end

    assign halted = halted_r;

    // Next state and pipeline controls; ex_* are only looked at in RUN so X cannot leak
    always_comb begin
        state_nxt_s = state_r;
        drain_nxt_s = drain_cnt_r;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        lu_s        = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_r)
            RUN: begin
                lu_s = ex_mem_read && (ex_rd != {REG_IDX_W{1'b0}}) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
                if (ex_halt) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    drain_nxt_s = DW'(DRAIN_CYCLES - 1);
                    state_nxt_s = DRAIN;
                end else if (ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc_s = 1'b1;
                end else if (lu_s) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_inc_s = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (drain_cnt_r == {DW{1'b0}}) begin
                    state_nxt_s = HALTED;
                end else begin
                    drain_nxt_s = drain_cnt_r - DW'(1);
                end
            end
            HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt_s = RUN;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: load-use, redirect, halt drain,
// mid-drain reset and counter saturation on a narrow-counter instance.
module tb_pipeline_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_redirect = 1'b0;
    logic        ex_halt = 1'b0;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_flush4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_sequencer #(.DRAIN_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .if_id_flush(if_id_flush4),
        .id_ex_flush(id_ex_flush4), .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; ex_halt = 1'b0;
    endtask

    initial begin
        // reset state, sampled while rst_n is held low
        #1 rst_n = 1'b0;
        #2;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_if_id_write", {31'd0, if_id_write}, 32'd1);
        chk("rst_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1. load x5 in EX, ID reads rs1=x5
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        chk("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        chk("lu_if_id_flush", {31'd0, if_id_flush}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("lu_release_pc", {31'd0, pc_write}, 32'd1);
        chk("lu_release_idex", {31'd0, id_ex_flush}, 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // rs2 match stalls; same match with use_rs2 low does not
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1 chk("lu_rs2_pc", {31'd0, pc_write}, 32'd0);
        @(negedge clk);
        id_use_rs2 = 1'b0;
        #1 chk("lu_rs2_unused_pc", {31'd0, pc_write}, 32'd1);
        chk("lu_rs2_stall_cnt", stall_cnt, 32'd2);

        // 2. x0 destination never stalls; non-load never stalls
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        chk("x0_pc_write", {31'd0, pc_write}, 32'd1);
        chk("x0_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
        @(negedge clk);
        ex_mem_read = 1'b0; ex_rd = 5'd9; id_rs1 = 5'd9;
        #1 chk("noload_pc_write", {31'd0, pc_write}, 32'd1);
        @(negedge clk);
        idle();
        #1 chk("x0_stall_cnt", stall_cnt, 32'd2);

        // 3. redirect with a simultaneous load-use: squash wins
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
        #1;
        chk("redir_pc_write", {31'd0, pc_write}, 32'd1);
        chk("redir_if_id_flush", {31'd0, if_id_flush}, 32'd1);
        chk("redir_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
        @(negedge clk);
        ex_mem_read = 1'b0; id_use_rs1 = 1'b0;
        #1;
        chk("redir_flush_cnt", flush_cnt, 32'd1);
        chk("redir_stall_cnt", stall_cnt, 32'd2);
        @(negedge clk);
        idle();
        #1 chk("redir2_flush_cnt", flush_cnt, 32'd2);

        // 4. halt beats redirect and load-use; halted rises 3 edges later
        @(negedge clk);
        ex_halt = 1'b1; ex_redirect = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
        #1;
        chk("halt_pc_write", {31'd0, pc_write}, 32'd0);
        chk("halt_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        @(negedge clk);
        ex_halt = 1'b0;
        #1;
        chk("drain_pc_write", {31'd0, pc_write}, 32'd0);
        chk("drain_if_id_write", {31'd0, if_id_write}, 32'd0);
        chk("drain_halted_e1", {31'd0, halted}, 32'd0);
        chk("halt_no_flush_inc", flush_cnt, 32'd2);
        chk("halt_no_stall_inc", stall_cnt, 32'd2);
        @(negedge clk);
        #1 chk("drain_halted_e2", {31'd0, halted}, 32'd0);
        @(negedge clk);
        #1 chk("drain_halted_e3", {31'd0, halted}, 32'd0);
        @(negedge clk);
        #1 chk("halted_rise", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ex_mem_read = 1'($urandom); ex_rd = 5'($urandom); ex_redirect = 1'($urandom);
            ex_halt = 1'($urandom); id_rs1 = ex_rd; id_use_rs1 = 1'b1;
            #1;
            chk("halted_sticky", {28'd0, halted, pc_write, if_id_flush, id_ex_flush}, 32'b1011);
        end
        chk("halted_stall_cnt", stall_cnt, 32'd2);
        chk("halted_flush_cnt", flush_cnt, 32'd2);

        // 5. reset mid-drain
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6; id_use_rs1 = 1'b1;
        @(negedge clk);
        idle();
        ex_halt = 1'b1;
        #1 chk("pre_drain_stall_cnt", stall_cnt, 32'd1);
        @(negedge clk);
        ex_halt = 1'b0;
        #1 chk("in_drain_pc_write", {31'd0, pc_write}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("midrst_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("postrst_halted", {31'd0, halted}, 32'd0);
        chk("postrst_pc_write", {31'd0, pc_write}, 32'd1);

        // 6. counter saturation on the 4-bit instance
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs2 = 5'd8; id_use_rs2 = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        chk("sat_cnt4_14", {28'd0, stall_cnt4}, 32'd14);
        chk("sat_cnt32_14", stall_cnt, 32'd14);
        repeat (6) @(negedge clk);
        #1;
        chk("sat_cnt4_20", {28'd0, stall_cnt4}, 32'hF);
        chk("sat_cnt32_20", stall_cnt, 32'd20);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
